store_buffer: RTL and testbench

- Memory-stage store path: the write-side counterpart of the write-back load-extension logic.
- Accepts sw/sh/sb requests from the M stage and checks alignment.
- Generates word-aligned write data and byte enables, then queues them in a small FIFO.
- Drains the FIFO to the data-memory bus under a req/ack handshake; flags pending-store address hits so the hazard unit can stall dependent loads.

---
 rtl/store_buffer_pkg.sv | 27 ++
 rtl/store_buffer_if.sv | 38 +++
 rtl/store_buffer_align.sv | 40 ++++
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the memory-stage store path: store type codes,
// byte-enable patterns and the layout of one queued store entry.
package store_buffer_pkg;

    localparam int unsigned SB_AW   = 32;
    localparam int unsigned WORD_AW = SB_AW - 2;
    localparam int unsigned DW      = 32;
    localparam int unsigned BW      = DW / 8;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    localparam logic [BW-1:0] BE_NONE    = 4'b0000;
    localparam logic [BW-1:0] BE_WORD    = 4'b1111;
    localparam logic [BW-1:0] BE_LO_HALF = 4'b0011;
    localparam logic [BW-1:0] BE_HI_HALF = 4'b1100;
    localparam logic [BW-1:0] BE_BYTE0   = 4'b0001;

    typedef struct packed {
        logic [WORD_AW-1:0] word_addr;
        logic [DW-1:0]      wdata;
        logic [BW-1:0]      be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store request, load-hazard probe and data-memory write bus of the store buffer.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [1:0]    st_type;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_addr_err;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_be;
    logic          bus_ack;
    logic [CW-1:0] count;
    logic          empty;

    // Requester / memory side
    modport master (
        output st_valid, st_type, st_addr, st_data, ld_addr, bus_ack,
        input  st_ready, st_addr_err, ld_hit, bus_req, bus_addr, bus_wdata,
               bus_be, count, empty
    );

    // Store buffer side
    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_addr, bus_ack,
        output st_ready, st_addr_err, ld_hit, bus_req, bus_addr, bus_wdata,
               bus_be, count, empty
    );

endinterface

// File: rtl/store_buffer_align.sv
// Store alignment check and write-data/byte-enable formatting; purely
// combinational so an uncached store path can reuse it unchanged.
module store_buffer_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]    st_type,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] st_data,
    output logic          legal_c,
    output logic [BW-1:0] be_c,
    output logic [DW-1:0] wdata_c
);

    always_comb begin
        legal_c = 1'b0;
        be_c    = BE_NONE;
        wdata_c = '0;
        case (st_type)
            ST_SW: begin
                legal_c = (addr_lo == 2'b00);
                be_c    = BE_WORD;
                wdata_c = st_data;
            end
            ST_SH: begin
                legal_c = !addr_lo[0];
                be_c    = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata_c = {2{st_data[15:0]}};
            end
            ST_SB: begin
                legal_c = 1'b1;
                be_c    = BE_BYTE0 << addr_lo;
                wdata_c = {4{st_data[7:0]}};
            end
            default: begin
                legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Memory-stage store buffer: formats sw/sh/sb stores, queues them in order and
// drains them to data memory over req/ack, flagging loads that hit a pending word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          legal_c;
    logic [BW-1:0] be_c;
    logic [DW-1:0] wdata_c;

    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic      st_ready_c;
    logic      empty_c;
    logic      enq_c;
    logic      deq_c;
    logic      ld_hit_c;
    sb_entry_t head_c;
    logic      unused_ld_lo;

    store_buffer_align u_align (
        .st_type (sb.st_type),
        .addr_lo (sb.st_addr[1:0]),
        .st_data (sb.st_data),
        .legal_c (legal_c),
        .be_c    (be_c),
        .wdata_c (wdata_c)
    );

    // Readiness comes from the pre-edge count, so a full buffer never
    // accepts a store even when the head drains on the same edge.
    assign st_ready_c = (count_q != CW'(DEPTH));
    assign empty_c    = (count_q == '0);
    assign enq_c      = sb.st_valid && legal_c && st_ready_c;
    assign deq_c      = !empty_c && sb.bus_ack;
    assign head_c     = entry_q[head_q];

    // Next-state for queue storage, pointers, occupancy and error pulse
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = sb.st_valid && !legal_c;
        if (enq_c) begin
            entry_d[tail_q] = '{word_addr: WORD_AW'(sb.st_addr[AW-1:2]),
                                wdata:     wdata_c,
                                be:        be_c};
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (deq_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        case ({enq_c, deq_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Payload storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    // Word-granular hazard probe; the store being enqueued is not yet valid.
    always_comb begin
        ld_hit_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].word_addr == WORD_AW'(sb.ld_addr[AW-1:2]))) begin
                ld_hit_c = 1'b1;
            end
        end
    end

    assign unused_ld_lo = ^sb.ld_addr[1:0];

    assign sb.st_ready    = st_ready_c;
    assign sb.st_addr_err = err_q;
    assign sb.ld_hit      = ld_hit_c;
    assign sb.bus_req     = !empty_c;
    assign sb.bus_addr    = {(AW-2)'(head_c.word_addr), 2'b00};
    assign sb.bus_wdata   = head_c.wdata;
    assign sb.bus_be      = head_c.be;
    assign sb.count       = count_q;
    assign sb.empty       = empty_c;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: formatting, alignment errors, full/drain
// ordering, load-hit probing, pointer wrap and asynchronous reset.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    logic [7:0]  eb;
    logic [31:0] ea;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d);
        sbif.st_valid = v;
        sbif.st_type  = t;
        sbif.st_addr  = a;
        sbif.st_data  = d;
    endtask

    initial begin
        reset        = 1'b0;
        sbif.bus_ack = 1'b0;
        sbif.ld_addr = '0;
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        step();
        step();
        check("rst_bus_req", sbif.bus_req, 1'b0);
        check("rst_err", sbif.st_addr_err, 1'b0);
        check("rst_empty", sbif.empty, 1'b1);
        check("rst_ready", sbif.st_ready, 1'b1);
        check("rst_count", sbif.count, 3'd0);
        reset = 1'b1;

        // SB with ack tied high: one cycle to bus_req, dequeued the next edge
        sbif.bus_ack = 1'b1;
        drive(1'b1, ST_SB, 32'h1003, 32'h0000_00A5);
        check("sb_ready", sbif.st_ready, 1'b1);
        step();
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        check("sb_req", sbif.bus_req, 1'b1);
        check("sb_addr", sbif.bus_addr, 32'h1000);
        check("sb_be", sbif.bus_be, 4'b1000);
        check("sb_wdata", sbif.bus_wdata, 32'hA5A5_A5A5);
        check("sb_count", sbif.count, 3'd1);
        step();
        check("sb_deq_req", sbif.bus_req, 1'b0);
        check("sb_deq_empty", sbif.empty, 1'b1);
        sbif.bus_ack = 1'b0;

        // SH upper half, then misaligned SW and reserved type
        drive(1'b1, ST_SH, 32'h2002, 32'h1234_BEEF);
        step();
        drive(1'b1, ST_SW, 32'h2001, 32'hFFFF_FFFF);
        check("sh_be", sbif.bus_be, 4'b1100);
        check("sh_wdata", sbif.bus_wdata, 32'hBEEF_BEEF);
        check("sh_addr", sbif.bus_addr, 32'h2000);
        check("sh_err_before", sbif.st_addr_err, 1'b0);
        step();
        drive(1'b1, ST_RSV, 32'h2004, 32'h0);
        check("sw_mis_err", sbif.st_addr_err, 1'b1);
        check("sw_mis_count", sbif.count, 3'd1);
        step();
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        check("rsv_err_b2b", sbif.st_addr_err, 1'b1);
        check("rsv_count", sbif.count, 3'd1);
        step();
        check("err_clear", sbif.st_addr_err, 1'b0);
        check("err_count", sbif.count, 3'd1);
        sbif.bus_ack = 1'b1;
        step();
        check("sh_drained", sbif.count, 3'd0);
        sbif.bus_ack = 1'b0;

        // Fill to full, hold fifth, release one slot, drain in order
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ST_SW, 32'h100 + 32'(4 * k), 32'h1000_0001 + 32'(k));
            check("fill_ready", sbif.st_ready, 1'b1);
            step();
        end
        check("full_count", sbif.count, 3'd4);
        check("full_ready", sbif.st_ready, 1'b0);
        drive(1'b1, ST_SW, 32'h110, 32'h1000_0005);
        step();
        check("full_held", sbif.count, 3'd4);
        check("full_head", sbif.bus_wdata, 32'h1000_0001);
        sbif.bus_ack = 1'b1;
        check("full_head_addr", sbif.bus_addr, 32'h100);
        step();
        check("full_deq_no_enq", sbif.count, 3'd3);
        check("full_new_head", sbif.bus_wdata, 32'h1000_0002);
        sbif.bus_ack = 1'b0;
        step();
        check("fifth_enq", sbif.count, 3'd4);
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        sbif.bus_ack = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("order_wdata", sbif.bus_wdata, 32'h1000_0001 + 32'(k));
            check("order_addr", sbif.bus_addr, 32'h100 + 32'(4 * k));
            step();
        end
        check("order_empty", sbif.count, 3'd0);
        sbif.bus_ack = 1'b0;

        // Load-hit probing at word granularity
        drive(1'b1, ST_SW, 32'h3000, 32'hAAAA_0000);
        step();
        drive(1'b1, ST_SW, 32'h3008, 32'hAAAA_0008);
        step();
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        sbif.ld_addr = 32'h3002;
        #1 check("hit_3002", sbif.ld_hit, 1'b1);
        sbif.ld_addr = 32'h3004;
        #1 check("hit_3004", sbif.ld_hit, 1'b0);
        sbif.ld_addr = 32'h300B;
        #1 check("hit_300b", sbif.ld_hit, 1'b1);
        drive(1'b1, ST_SW, 32'h3010, 32'hAAAA_0010);
        sbif.ld_addr = 32'h3010;
        #1 check("hit_enq_excluded", sbif.ld_hit, 1'b0);
        step();
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        check("hit_3010_pending", sbif.ld_hit, 1'b1);
        sbif.ld_addr = 32'h3000;
        sbif.bus_ack = 1'b1;
        #1 check("hit_deq_included", sbif.ld_hit, 1'b1);
        step();
        check("hit_after_deq", sbif.ld_hit, 1'b0);
        step();
        step();
        check("hit_drained", sbif.count, 3'd0);
        sbif.ld_addr = 32'h3008;
        #1 check("hit_3008_gone", sbif.ld_hit, 1'b0);
        sbif.ld_addr = 32'h3000;
        #1 check("hit_3000_gone", sbif.ld_hit, 1'b0);
        sbif.bus_ack = 1'b0;

        // Simultaneous enqueue/dequeue at count 2, wrapping over 10 stores
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ST_SB, 32'h4000 + 32'(i), 32'h0000_00C0 + 32'(i));
            step();
        end
        check("wrap_count2", sbif.count, 3'd2);
        sbif.bus_ack = 1'b1;
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, ST_SB, 32'h4000 + 32'(i), 32'h0000_00C0 + 32'(i));
            eb = 8'hC0 + 8'(i - 2);
            ea = (32'h4000 + 32'(i - 2)) & ~32'h3;
            check("wrap_wdata", sbif.bus_wdata, {4{eb}});
            check("wrap_be", sbif.bus_be, 4'b0001 << ((i - 2) % 4));
            check("wrap_addr", sbif.bus_addr, ea);
            step();
            check("wrap_count_steady", sbif.count, 3'd2);
        end
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        for (int i = 8; i < 10; i++) begin
            eb = 8'hC0 + 8'(i);
            ea = (32'h4000 + 32'(i)) & ~32'h3;
            check("wrap_tail_wdata", sbif.bus_wdata, {4{eb}});
            check("wrap_tail_be", sbif.bus_be, 4'b0001 << (i % 4));
            check("wrap_tail_addr", sbif.bus_addr, ea);
            step();
        end
        check("wrap_empty", sbif.empty, 1'b1);
        sbif.bus_ack = 1'b0;

        // Asynchronous reset mid-drain with an error pulse outstanding
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ST_SW, 32'h5000 + 32'(4 * k), 32'h5500_0000 + 32'(k));
            step();
        end
        drive(1'b1, ST_SW, 32'h5001, 32'h0);
        step();
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        check("pre_rst_err", sbif.st_addr_err, 1'b1);
        check("pre_rst_count", sbif.count, 3'd3);
        check("pre_rst_req", sbif.bus_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", sbif.bus_req, 1'b0);
        check("arst_count", sbif.count, 3'd0);
        check("arst_err", sbif.st_addr_err, 1'b0);
        check("arst_empty", sbif.empty, 1'b1);
        check("arst_ready", sbif.st_ready, 1'b1);
        #2 reset = 1'b1;
        drive(1'b1, ST_SW, 32'h5010, 32'hDEAD_BEEF);
        step();
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        check("post_rst_count", sbif.count, 3'd1);
        check("post_rst_req", sbif.bus_req, 1'b1);
        check("post_rst_wdata", sbif.bus_wdata, 32'hDEAD_BEEF);
        check("post_rst_addr", sbif.bus_addr, 32'h5010);
        check("post_rst_be", sbif.bus_be, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
